// File: rtl/lifo_arb_pkg.sv
// Shared types for the LIFO request arbiter: FSM state encoding and op codes.
// No logic; latency and backpressure are defined by the modules that import it.
// Op code 0 pushes and 1 pops, matching the per-client req_op_i bit.
package lifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin pick: first set request at or after ptr_i, wrapping.
// Purely combinational, zero latency.
// No backpressure; vld_o is low when no request is set.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        // Scan from the farthest offset down so the nearest set bit wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                idx_o = IW'(j);
                vld_o = 1'b1;
            end
        end
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/lifo_req_arbiter.sv
// Round-robin sharing of one LIFO stack among N_REQ clients; LIFO_ARB_ERR_CNT_EN adds err counter.
// Latency: req->gnt 2 cycles, pop gnt->rsp_valid 2 cycles; push 2 cycles/op, pop 4 cycles/op.
// Backpressure: clients hold req until gnt; push@full and pop@empty are granted with rsp_err.
module lifo_req_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           req_op_i,
    input  logic [N_REQ*DW-1:0]        req_data_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic                       rsp_err_o,
    output logic [N_REQ-1:0]           rsp_valid_o,
    output logic [DW-1:0]              rsp_data_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       stk_push_o,
    output logic                       stk_pop_o,
    output logic [DW-1:0]              stk_din_o,
    input  logic [DW-1:0]              stk_dout_i,
    output logic [15:0]                err_cnt_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] win_oh_q, win_oh_d;
    logic             op_q, op_d;
    logic [DW-1:0]    data_q, data_d;
    logic [LW-1:0]    level_q, level_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rsp_err_q, rsp_err_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;
    logic             stk_push_q, stk_push_d;
    logic             stk_pop_q, stk_pop_d;
    logic [DW-1:0]    stk_din_q, stk_din_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_vld;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_oh_d    = win_oh_q;
        op_d        = op_q;
        data_d      = data_q;
        level_d     = level_q;
        gnt_d       = '0;
        rsp_err_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        stk_din_d   = stk_din_q;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    win_oh_d = arb_gnt;
                    op_d     = req_op_i[arb_idx];
                    data_d   = req_data_i[int'(arb_idx)*DW +: DW];
                    rr_ptr_d = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                gnt_d   = win_oh_q;
                state_d = IDLE;
                if (op_q == OP_PUSH) begin
                    if (level_q == LW'(DEPTH)) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        stk_push_d = 1'b1;
                        stk_din_d  = data_q;
                        level_d    = level_q + 1'b1;
                    end
                end else begin
                    if (level_q == '0) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        stk_pop_d = 1'b1;
                        level_d   = level_q - 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            // The stack presents its data the cycle after the pop strobe is seen.
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_d = win_oh_q;
                rsp_data_d  = stk_dout_i;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_oh_q    <= '0;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            level_q     <= '0;
            gnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            stk_push_q  <= 1'b0;
            stk_pop_q   <= 1'b0;
            stk_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_oh_q    <= win_oh_d;
            op_q        <= op_d;
            data_q      <= data_d;
            level_q     <= level_d;
            gnt_q       <= gnt_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            stk_push_q  <= stk_push_d;
            stk_pop_q   <= stk_pop_d;
            stk_din_q   <= stk_din_d;
        end
    end

`ifdef LIFO_ARB_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Counts alongside the registered rsp_err so both become visible together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else if (rsp_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign gnt_o       = gnt_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign level_o     = level_q;
    assign stk_push_o  = stk_push_q;
    assign stk_pop_o   = stk_pop_q;
    assign stk_din_o   = stk_din_q;

endmodule

// File: tb/tb_lifo_req_arbiter.sv
// Directed bench for lifo_req_arbiter with a behavioural 8-deep stack on the stack port.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lifo_req_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
`ifdef LIFO_ARB_ERR_CNT_EN
    localparam int EXP_ERR = 3;
`else
    localparam int EXP_ERR = 0;
`endif

    logic               clk;
    logic               rstn;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   req_op;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]   gnt;
    logic               rsp_err;
    logic [N_REQ-1:0]   rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [3:0]         level;
    logic               stk_push;
    logic               stk_pop;
    logic [DW-1:0]      stk_din;
    logic [DW-1:0]      stk_dout;
    logic [15:0]        err_cnt;

    int checks = 0;
    int errors = 0;

    lifo_req_arbiter #(.N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (req),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .gnt_o       (gnt),
        .rsp_err_o   (rsp_err),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .level_o     (level),
        .stk_push_o  (stk_push),
        .stk_pop_o   (stk_pop),
        .stk_din_o   (stk_din),
        .stk_dout_i  (stk_dout),
        .err_cnt_o   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: shares rstn, read data valid the cycle after the pop strobe.
    logic [DW-1:0] mem [0:DEPTH-1];
    int sp;
    always @(posedge clk) begin
        if (!rstn) begin
            sp       <= 0;
            stk_dout <= '0;
        end else begin
            if (stk_push && sp < DEPTH) begin
                mem[sp] <= stk_din;
                sp      <= sp + 1;
            end
            if (stk_pop && sp > 0) begin
                stk_dout <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Waits (bounded) for any grant, then checks it went to client c.
    task automatic wait_gnt(input int c);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 12);
        check("gnt_onehot", 32'(gnt), 32'(1) << c);
    endtask

    task automatic post(input int c, input logic op, input logic [DW-1:0] d);
        req_op[c]          = op;
        req_data[c*DW +: DW] = d;
        req[c]             = 1'b1;
    endtask

    task automatic push_op(input int c, input logic [DW-1:0] d);
        post(c, 1'b0, d);
        wait_gnt(c);
        req[c] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        req      = '0;
        req_op   = '0;
        req_data = '0;
        rstn     = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_stk", {29'd0, stk_push, stk_pop, 1'b0}, 0);
        check("rst_stk_din", 32'(stk_din), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        // Client 0 push A5: grant exactly 2 cycles after req
        rstn = 1'b1;
        post(0, 1'b0, 8'hA5);
        tick();
        check("push_gnt_early", 32'(gnt), 0);
        tick();
        check("push_gnt_lat2", 32'(gnt), 32'h1);
        check("push_strobe", 32'(stk_push), 1);
        check("push_no_pop", 32'(stk_pop), 0);
        check("push_din", 32'(stk_din), 32'hA5);
        check("push_err", 32'(rsp_err), 0);
        check("push_level", 32'(level), 1);
        req[0] = 1'b0;
        tick();
        check("push_gnt_pulse", 32'(gnt), 0);

        // Push A1, A2 then client 2 pops A2
        do_reset();
        push_op(0, 8'hA1);
        push_op(1, 8'hA2);
        check("pp_level2", 32'(level), 2);
        post(2, 1'b1, 8'h00);
        wait_gnt(2);
        req[2] = 1'b0;
        check("pop_strobe", 32'(stk_pop), 1);
        check("pop_level", 32'(level), 1);
        check("pop_err", 32'(rsp_err), 0);
        tick();
        check("pop_rsp_early", 32'(rsp_valid), 0);
        tick();
        check("pop_rsp_valid", 32'(rsp_valid), 32'h4);
        check("pop_rsp_data", 32'(rsp_data), 32'hA2);
        tick();
        check("pop_rsp_pulse", 32'(rsp_valid), 0);

        // All four clients push together from rr_ptr=0
        do_reset();
        for (int k = 0; k < N_REQ; k++) begin
            post(k, 1'b0, DW'(8'hB0 + k));
        end
        for (int k = 0; k < N_REQ; k++) begin
            wait_gnt(k);
            check("rr_din", 32'(stk_din), 32'hB0 + k);
            req[k] = 1'b0;
        end
        check("rr_level4", 32'(level), 4);

        // Empty pop, fill to DEPTH, two rejected pushes
        do_reset();
        post(1, 1'b1, 8'h00);
        wait_gnt(1);
        req[1] = 1'b0;
        check("empty_pop_err", 32'(rsp_err), 1);
        check("empty_pop_nostrobe", 32'(stk_pop), 0);
        check("empty_pop_level", 32'(level), 0);
        tick();
        check("err_pulse", 32'(rsp_err), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("empty_pop_no_rsp", 32'(rsp_valid), 0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            push_op(k % N_REQ, DW'(8'h10 + k));
        end
        check("fill_level8", 32'(level), 8);
        push_op(2, 8'h55);
        check("full_push_err", 32'(rsp_err), 1);
        check("full_push_nostrobe", 32'(stk_push), 0);
        check("full_push_level", 32'(level), 8);
        push_op(0, 8'h66);
        check("full_push2_err", 32'(rsp_err), 1);
        check("err_cnt", 32'(err_cnt), EXP_ERR);

        // Reset while in WAIT after a pop grant
        post(3, 1'b1, 8'h00);
        wait_gnt(3);
        req[3] = 1'b0;
        check("wait_pop_strobe", 32'(stk_pop), 1);
        rstn = 1'b0;
        tick();
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_stk", {30'd0, stk_push, stk_pop}, 0);
        check("mid_rst_rsp", {27'd0, rsp_err, rsp_valid}, 0);
        check("mid_rst_data", 32'(rsp_data), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_rsp", 32'(rsp_valid), 0);
        end

        // Normal traffic after the abort
        push_op(0, 8'h3C);
        check("after_rst_level", 32'(level), 1);
        post(1, 1'b1, 8'h00);
        wait_gnt(1);
        req[1] = 1'b0;
        tick();
        tick();
        check("after_rst_rsp_valid", 32'(rsp_valid), 32'h2);
        check("after_rst_rsp_data", 32'(rsp_data), 32'h3C);
        check("after_rst_level0", 32'(level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
